// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// The lock FSM states are only exercised when ARB_LOCK_EN is defined.
package mem_arb_pkg;

  localparam int ARB_ADDR_W = 10;
  localparam int ARB_DATA_W = 32;
  localparam int MEM_ADDR_W = 32;

  localparam int PORT_CPU  = 0;
  localparam int PORT_HOST = 1;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  // Ports eligible for a grant in each arbiter state.
  function automatic logic [1:0] port_mask(
    input arb_state_e s
  );
    logic [1:0] m;
    m = 2'b11;
    unique case (s)
      ARB:     m = 2'b11;
      LOCK0:   m = 2'b01;
      LOCK1:   m = 2'b10;
      default: m = 2'b11;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker.
// Ties go to the port that did not win last.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic [1:0] mask,
  output logic [1:0] grant
);

  logic [1:0] elig;

  assign elig = valid & mask;

  always_comb begin
    grant = 2'b00;
    unique case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory between CPU and host ports.
// Optional bus locking is built in when ARB_LOCK_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ARB_ADDR_W,
  parameter int DATA_W   = ARB_DATA_W,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              r0_valid,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r0_lock,
  output logic              r0_ready,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,

  input  logic              r1_valid,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  input  logic              r1_lock,
  output logic              r1_ready,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,

  output logic              mem_we,
  output logic [31:0]       mem_raddr,
  output logic [31:0]       mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int PAD_W = MEM_ADDR_W - ADDR_W;

  logic [1:0]        req_valid;
  logic [1:0]        mask;
  logic [1:0]        grant;
  logic [1:0]        ready;
  logic              xfer;
  logic              xfer_port;
  logic              g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic [31:0]       g_maddr;
  logic              lock_exit;
  logic              lock_port;

  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              last_grant_q, last_grant_d;

  assign req_valid = {r1_valid, r0_valid};

  rr_pick2 u_pick (
    .valid      (req_valid),
    .last_grant (last_grant_q),
    .mask       (mask),
    .grant      (grant)
  );

  // A grant is only ever issued to a valid port, so ready implies transfer.
  assign ready     = rst ? 2'b00 : grant;
  assign r0_ready  = ready[PORT_CPU];
  assign r1_ready  = ready[PORT_HOST];
  assign xfer      = |ready;
  assign xfer_port = ready[PORT_HOST];

  assign g_we    = xfer_port ? r1_we    : r0_we;
  assign g_addr  = xfer_port ? r1_addr  : r0_addr;
  assign g_wdata = xfer_port ? r1_wdata : r0_wdata;
  assign g_maddr = {{PAD_W{1'b0}}, g_addr};

  assign mem_we    = xfer & g_we;
  assign mem_raddr = xfer ? g_maddr : addr_q;
  assign mem_waddr = xfer ? g_maddr : addr_q;
  assign mem_wdata = xfer ? g_wdata : wdata_q;

  assign r0_rvalid = rvalid_q[PORT_CPU];
  assign r1_rvalid = rvalid_q[PORT_HOST];
  assign r0_rdata  = rdata0_q;
  assign r1_rdata  = rdata1_q;

  always_comb begin
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rvalid_d     = 2'b00;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    last_grant_d = last_grant_q;
    if (xfer) begin
      addr_d       = g_maddr;
      wdata_d      = g_wdata;
      last_grant_d = xfer_port;
      if (!g_we) begin
        rvalid_d[xfer_port] = 1'b1;
        if (xfer_port) rdata1_d = mem_rdata;
        else           rdata0_d = mem_rdata;
      end
    end
    if (lock_exit) last_grant_d = lock_port;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      rvalid_q     <= 2'b00;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      last_grant_q <= 1'b1;
    end else begin
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rvalid_q     <= rvalid_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef ARB_LOCK_EN

  localparam int CNT_W = $clog2(LOCK_MAX + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_nxt;
  logic             g_lock;
  logic             own_lock;

  assign g_lock    = xfer_port ? r1_lock : r0_lock;
  assign lock_port = (state_q == LOCK1);
  assign own_lock  = lock_port ? r1_lock : r0_lock;
  assign mask      = port_mask(state_q);
  assign cnt_nxt   = cnt_q + CNT_ONE;

  // The counter includes the locking transfer itself.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lock_exit = 1'b0;
    unique case (state_q)
      ARB: begin
        if (xfer && g_lock) begin
          state_d = xfer_port ? LOCK1 : LOCK0;
          cnt_d   = CNT_ONE;
        end
      end
      LOCK0, LOCK1: begin
        cnt_d = cnt_nxt;
        if (!own_lock || cnt_nxt >= CNT_MAX) begin
          state_d   = ARB;
          cnt_d     = '0;
          lock_exit = 1'b1;
        end
      end
      default: begin
        state_d = ARB;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`else

  assign mask      = 2'b11;
  assign lock_exit = 1'b0;
  assign lock_port = 1'b0;

  logic unused_cfg;
  assign unused_cfg = r0_lock ^ r1_lock ^ (LOCK_MAX > 0);

`endif

endmodule
